// File: rtl/mcu_bus_tx.sv
// rtl/mcu_bus_tx.sv - byte-wide strobed MCU bus transmitter with input queue
// Define MCU_BUS_TX_FIFO_EN for a 4-entry queue; default is a single holding register.
module mcu_bus_tx #(
    parameter int SETUP_CYCLES = 2,
    parameter int HIGH_CYCLES  = 2,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [7:0] i_in_data,
    input  logic       i_in_command,
    output logic       o_bus_clock,
    output logic [7:0] o_bus,
    output logic       o_command_data,
    output logic       o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_HIGH, S_HOLD} state_t;

    localparam logic [7:0] L_SETUP = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] L_HIGH  = 8'(HIGH_CYCLES - 1);
    localparam logic [7:0] L_HOLD  = 8'(HOLD_CYCLES - 1);

    state_t     r_state, w_state_nx;
    logic [7:0] r_cnt, w_cnt_nx;
    logic [7:0] r_bus, w_bus_nx;
    logic       r_cmd, w_cmd_nx;
    logic       r_bclk, w_bclk_nx;
    logic       r_busy, w_busy_nx;
    logic       w_full, w_empty, w_push, w_pop, w_bypass, w_store, w_nonempty_nx;
    logic [8:0] w_head;

    assign o_in_ready = !w_full;
    assign w_push     = i_in_valid && !w_full;
    // A byte arriving exactly as HOLD ends with nothing queued goes straight to the bus.
    assign w_store    = w_push && !w_bypass;

`ifdef MCU_BUS_TX_FIFO_EN
    logic [8:0] r_mem [0:3];
    logic [1:0] r_wptr, r_rptr;
    logic [2:0] r_count, w_count_nx;

    assign w_full        = (r_count == 3'd4);
    assign w_empty       = (r_count == 3'd0);
    assign w_head        = r_mem[r_rptr];
    assign w_count_nx    = r_count + {2'b00, w_store} - {2'b00, w_pop};
    assign w_nonempty_nx = (w_count_nx != 3'd0);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_store) r_wptr <= r_wptr + 2'd1;
            if (w_pop)   r_rptr <= r_rptr + 2'd1;
            r_count <= w_count_nx;
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_store) r_mem[r_wptr] <= {i_in_command, i_in_data};
    end
`else
    logic [8:0] r_hold;
    logic       r_full;

    assign w_full        = r_full;
    assign w_empty       = !r_full;
    assign w_head        = r_hold;
    assign w_nonempty_nx = w_store || (r_full && !w_pop);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_full <= 1'b0;
            r_hold <= 9'd0;
        end else if (w_store) begin
            r_full <= 1'b1;
            r_hold <= {i_in_command, i_in_data};
        end else if (w_pop) begin
            r_full <= 1'b0;
        end
    end
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = (r_cnt != 8'd0) ? r_cnt - 8'd1 : 8'd0;
        w_bus_nx   = r_bus;
        w_cmd_nx   = r_cmd;
        w_pop      = 1'b0;
        w_bypass   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_bus_nx = 8'h00;
                w_cmd_nx = 1'b0;
                w_cnt_nx = 8'd0;
                if (!w_empty) begin
                    w_state_nx = S_SETUP;
                    w_cnt_nx   = L_SETUP;
                    w_pop      = 1'b1;
                    w_bus_nx   = w_head[7:0];
                    w_cmd_nx   = w_head[8];
                end
            end
            S_SETUP: begin
                if (r_cnt == 8'd0) begin
                    w_state_nx = S_HIGH;
                    w_cnt_nx   = L_HIGH;
                end
            end
            S_HIGH: begin
                if (r_cnt == 8'd0) begin
                    w_state_nx = S_HOLD;
                    w_cnt_nx   = L_HOLD;
                end
            end
            S_HOLD: begin
                if (r_cnt == 8'd0) begin
                    if (!w_empty) begin
                        w_state_nx = S_SETUP;
                        w_cnt_nx   = L_SETUP;
                        w_pop      = 1'b1;
                        w_bus_nx   = w_head[7:0];
                        w_cmd_nx   = w_head[8];
                    end else if (w_push) begin
                        w_state_nx = S_SETUP;
                        w_cnt_nx   = L_SETUP;
                        w_bypass   = 1'b1;
                        w_bus_nx   = i_in_data;
                        w_cmd_nx   = i_in_command;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = 8'd0;
                        w_bus_nx   = 8'h00;
                        w_cmd_nx   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = 8'd0;
                w_bus_nx   = 8'h00;
                w_cmd_nx   = 1'b0;
            end
        endcase
    end

    assign w_bclk_nx = (w_state_nx == S_HIGH);
    assign w_busy_nx = (w_state_nx != S_IDLE) || w_nonempty_nx;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_bus   <= 8'h00;
            r_cmd   <= 1'b0;
            r_bclk  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_bus   <= w_bus_nx;
            r_cmd   <= w_cmd_nx;
            r_bclk  <= w_bclk_nx;
            r_busy  <= w_busy_nx;
        end
    end

    assign o_bus_clock    = r_bclk;
    assign o_bus          = r_bus;
    assign o_command_data = r_cmd;
    assign o_busy         = r_busy;

endmodule

// File: doc/mcu_bus_tx.md
MCU_BUS_TX -- requirements
Module: mcu_bus_tx

Interface
REQ-001 SETUP_CYCLES, 2, cycles the bus byte is driven with bus_clock low before the rising edge; legal range 1..255.
REQ-002 HIGH_CYCLES, 2, cycles bus_clock is held high; legal range 1..255.
REQ-003 HOLD_CYCLES, 1, cycles bus_clock is low with the byte still held after the falling edge; legal range 1..255.
REQ-004 clock  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers one byte.
REQ-007 in_ready  output  1  block accepts the offered byte.
REQ-008 in_data  input  8  byte to transmit.
REQ-009 in_command  input  1  1 = command byte, 0 = data byte.
REQ-010 bus_clock  output  1  strobe to the receiver; the receiver samples on its rising edge.
REQ-011 bus  output  8  parallel bus byte.
REQ-012 command_data  output  1  command/data flag that travels with the bus byte.
REQ-013 busy  output  1  high while a transfer is in progress or a byte is queued.

Function
REQ-014 A byte SHALL be accepted on each rising clock edge where in_valid and in_ready are both high; in_ready SHALL be derived only from registered occupancy (not full).
REQ-015 The state machine SHALL have the states IDLE, SETUP, HIGH and HOLD; all outputs SHALL be registered.
REQ-016 IDLE: bus_clock=0, bus=8'h00, command_data=0; the block SHALL go to SETUP on the edge after the queue becomes non-empty.
REQ-017 On entry to SETUP the block SHALL pop the head entry, drive bus and command_data from it, hold bus_clock=0, and stay SETUP_CYCLES cycles.
REQ-018 HIGH: bus_clock=1 for HIGH_CYCLES cycles, with bus and command_data unchanged.
REQ-019 HOLD: bus_clock=0 for HOLD_CYCLES cycles, with bus and command_data unchanged.
REQ-020 At the end of HOLD the block SHALL go directly to SETUP if the queue is non-empty, otherwise to IDLE.
REQ-021 Latency: a byte accepted at edge N into an empty queue in IDLE SHALL appear on bus from cycle N+1; bus_clock SHALL rise at edge N+1+SETUP_CYCLES.
REQ-022 Back-to-back transfer period: exactly SETUP_CYCLES+HIGH_CYCLES+HOLD_CYCLES cycles, with no IDLE cycle between transfers.
REQ-023 Full: in_ready=0; a pop in the same cycle SHALL NOT allow a push until the next cycle.
REQ-024 Empty: no pop SHALL occur; pointers SHALL wrap modulo the queue depth.
REQ-025 A push into an empty queue on the same edge that HOLD ends SHALL be transmitted next with no IDLE cycle.
REQ-026 busy SHALL be high when state is not IDLE or the queue is non-empty.
REQ-027 The cycle counter SHALL be 8 bits wide and SHALL reload on every state entry.

Reset
REQ-028 While reset is high: bus_clock=0, bus=8'h00, command_data=0, busy=0, state=IDLE, counter=0, queue flushed.
REQ-029 in_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-030 A reset in mid-transfer SHALL abort it immediately; the partial byte and any queued bytes SHALL be discarded and not resent.

Configuration
REQ-031 With MCU_BUS_TX_FIFO_EN defined, the queue SHALL be a 4-entry FIFO of {in_command, in_data}.
REQ-032 Without MCU_BUS_TX_FIFO_EN defined, the queue SHALL be a single holding register (depth 1), emptied on SETUP entry, so one byte can be accepted while another is on the bus.
REQ-033 Bus timing and outputs SHALL be identical in both builds; only capacity and in_ready behaviour differ.

Verification (defaults 2/2/1)
REQ-034 Single push at edge N of 8'hA5 with in_command=1 -> bus=8'hA5 and command_data=1 from N+1; bus_clock high at cycles N+3..N+4 and low at N+5; IDLE with bus=8'h00 at N+6.
REQ-035 Four pushes 8'h01..8'h04 with in_command=0, FIFO build -> four bus_clock pulses spaced 5 cycles apart, bytes in order, busy high throughout, then low.
REQ-036 Five pushes with in_valid held high, FIFO build -> in_ready low on the cycle after the queue fills; the fifth byte is accepted only after a pop; all five bytes are sent in order.
REQ-037 Reset asserted during HIGH of 8'h3C with 2 bytes queued -> bus_clock=0 and bus=8'h00 immediately; no further pulses after release; in_ready=1.
REQ-038 Non-FIFO build, push 8'h11 then 8'h22 -> 8'h22 is accepted during the 8'h11 transfer; in_ready is low until the 8'h22 transfer starts; the two pulses are 5 cycles apart.
